// File: rtl/hilo_mdu_pkg.sv
// ============================================================================
// Module   : hilo_mdu_pkg
// Brief    : Shared constants for the HI/LO multiply/divide unit: func codes,
//            iteration count, FSM state encoding and an operand helper.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package hilo_mdu_pkg;

  // Iterations per multi-cycle op; equals the operand width.
  localparam int MDU_ITERS = 32;

  // R-type function codes serviced by the MDU.
  localparam logic [5:0] FUNC_MTHI  = 6'h11;
  localparam logic [5:0] FUNC_MTLO  = 6'h13;
  localparam logic [5:0] FUNC_MULT  = 6'h18;
  localparam logic [5:0] FUNC_MULTU = 6'h19;
  localparam logic [5:0] FUNC_DIV   = 6'h1A;
  localparam logic [5:0] FUNC_DIVU  = 6'h1B;

  typedef enum logic [1:0] {
    MDU_IDLE = 2'd0,
    MDU_MUL  = 2'd1,
    MDU_DIV  = 2'd2
  } mdu_state_e;

  // Magnitude of a 32-bit operand; only negative values of signed ops flip.
  function automatic logic [31:0] mdu_mag(input logic [31:0] v, input logic is_signed);
    return (is_signed && v[31]) ? (~v + 32'd1) : v;
  endfunction

endpackage

`default_nettype wire

// File: rtl/hilo_mdu_divider.sv
// ============================================================================
// Module   : hilo_mdu_divider
// Brief    : Restoring unsigned divider datapath. One quotient bit per step;
//            the dividend is shifted out of the quotient register into a
//            W+1 bit partial remainder. Next-step values are exported so the
//            owner can commit the final step without an extra cycle.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module hilo_mdu_divider #(
  parameter int W = 32
) (
  input  logic         clk,
  input  logic         resetn,
  input  logic         load_i,
  input  logic         step_i,
  input  logic [W-1:0] dividend_i,
  input  logic [W-1:0] divisor_i,
  input  logic [W-1:0] divisor_q_unused_i,
  output logic [W-1:0] quo_next_o,
  output logic [W-1:0] rem_next_o
);

  logic [W-1:0] rem_q, rem_d;
  logic [W-1:0] quo_q, quo_d;
  logic [W-1:0] dsr_q;
  logic [W:0]   w_part;
  logic [W:0]   w_diff;
  logic         w_fits;

  // Trial subtraction of the divisor from the shifted partial remainder.
  always_comb begin
    w_part = {rem_q, quo_q[W-1]};
    w_diff = w_part - {1'b0, dsr_q};
    w_fits = (w_part >= {1'b0, dsr_q});
    rem_d  = w_fits ? w_diff[W-1:0] : w_part[W-1:0];
    quo_d  = {quo_q[W-2:0], w_fits};
  end

  // Load operands on accept, then advance one bit per enabled step.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      rem_q <= '0;
      quo_q <= '0;
      dsr_q <= '0;
    end else if (load_i) begin
      rem_q <= '0;
      quo_q <= dividend_i;
      dsr_q <= divisor_i ^ (divisor_q_unused_i & '0);
    end else if (step_i) begin
      rem_q <= rem_d;
      quo_q <= quo_d;
    end
  end

  assign quo_next_o = quo_d;
  assign rem_next_o = rem_d;

endmodule

`default_nettype wire

// File: rtl/hilo_mdu.sv
// ============================================================================
// Module   : hilo_mdu
// Brief    : Iterative multiply/divide unit owning the HI/LO pair. Runs
//            MULT/MULTU (shift-add) and DIV/DIVU (restoring) over ITERS
//            cycles, services MTHI/MTLO, exports busy/done for hazard logic.
//            Optional MDU_FAST_MUL_EN: single-cycle combinational multiply.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module hilo_mdu
  import hilo_mdu_pkg::*;
#(
  parameter int ITERS = MDU_ITERS
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic        start,
  input  logic [5:0]  func,
  input  logic [31:0] A,
  input  logic [31:0] B,
  input  logic        flush,
  output logic        busy,
  output logic        done,
  output logic [31:0] hi,
  output logic [31:0] lo
);

  localparam int CNT_W = $clog2(ITERS) + 1;

  mdu_state_e       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [31:0]      hi_q, hi_d, lo_q, lo_d;
  logic             done_q, done_d;
  logic [31:0]      mcand_q, mcand_d;
  logic [63:0]      acc_q, acc_d;
  logic             neg_res_q, neg_res_d;
  logic             neg_rem_q, neg_rem_d;

  logic        w_is_mul, w_is_div, w_signed, w_res_neg, w_last;
  logic [31:0] w_a_mag, w_b_mag;
  logic [32:0] w_sum;
  logic [63:0] w_acc_next;
  logic [31:0] w_quo_next, w_rem_next;
  logic        w_div_load, w_div_step;
`ifdef MDU_FAST_MUL_EN
  logic [63:0] w_fast_prod;
`endif

  // Operand decode and sign pre-fix shared by multiply and divide.
  always_comb begin
    w_is_mul   = (func == FUNC_MULT) || (func == FUNC_MULTU);
    w_is_div   = (func == FUNC_DIV)  || (func == FUNC_DIVU);
    w_signed   = (func == FUNC_MULT) || (func == FUNC_DIV);
    w_res_neg  = w_signed && (A[31] ^ B[31]);
    w_a_mag    = mdu_mag(A, w_signed);
    w_b_mag    = mdu_mag(B, w_signed);
    w_last     = (cnt_q == CNT_W'(ITERS - 1));
    w_sum      = {1'b0, acc_q[63:32]} + (acc_q[0] ? {1'b0, mcand_q} : 33'd0);
    w_acc_next = {w_sum, acc_q[31:1]};
    w_div_load = (state_q == MDU_IDLE) && start && !flush && w_is_div;
    w_div_step = (state_q == MDU_DIV) && !flush;
  end

`ifdef MDU_FAST_MUL_EN
  // Full-width product for the single-cycle multiply build.
  always_comb begin
    if (func == FUNC_MULT) begin
      w_fast_prod = $signed({{32{A[31]}}, A}) * $signed({{32{B[31]}}, B});
    end else begin
      w_fast_prod = {32'd0, A} * {32'd0, B};
    end
  end
`endif

  hilo_mdu_divider #(
    .W(32)
  ) u_divider (
    .clk                (clk),
    .resetn             (resetn),
    .load_i             (w_div_load),
    .step_i             (w_div_step),
    .dividend_i         (w_a_mag),
    .divisor_i          (w_b_mag),
    .divisor_q_unused_i (32'd0),
    .quo_next_o         (w_quo_next),
    .rem_next_o         (w_rem_next)
  );

  // Next-state: accept in IDLE, step while busy, commit on the last step.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    hi_d      = hi_q;
    lo_d      = lo_q;
    done_d    = 1'b0;
    mcand_d   = mcand_q;
    acc_d     = acc_q;
    neg_res_d = neg_res_q;
    neg_rem_d = neg_rem_q;
    if (flush) begin
      state_d = MDU_IDLE;
      cnt_d   = '0;
    end else begin
      case (state_q)
        MDU_IDLE: begin
          if (start) begin
            if (w_is_mul) begin
`ifdef MDU_FAST_MUL_EN
              {hi_d, lo_d} = w_fast_prod;
              done_d       = 1'b1;
`else
              state_d   = MDU_MUL;
              cnt_d     = '0;
              mcand_d   = w_a_mag;
              acc_d     = {32'd0, w_b_mag};
              neg_res_d = w_res_neg;
`endif
            end else if (w_is_div) begin
              state_d   = MDU_DIV;
              cnt_d     = '0;
              neg_res_d = w_res_neg;
              neg_rem_d = w_signed && A[31];
            end else if (func == FUNC_MTHI) begin
              hi_d = A;
            end else if (func == FUNC_MTLO) begin
              lo_d = A;
            end
          end
        end
        MDU_MUL: begin
          acc_d = w_acc_next;
          cnt_d = cnt_q + CNT_W'(1);
          if (w_last) begin
            {hi_d, lo_d} = neg_res_q ? (~w_acc_next + 64'd1) : w_acc_next;
            state_d      = MDU_IDLE;
            done_d       = 1'b1;
          end
        end
        MDU_DIV: begin
          cnt_d = cnt_q + CNT_W'(1);
          if (w_last) begin
            lo_d    = neg_res_q ? (~w_quo_next + 32'd1) : w_quo_next;
            hi_d    = neg_rem_q ? (~w_rem_next + 32'd1) : w_rem_next;
            state_d = MDU_IDLE;
            done_d  = 1'b1;
          end
        end
        default: state_d = MDU_IDLE;
      endcase
    end
  end

  // State, counter, datapath and HI/LO registers.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      state_q   <= MDU_IDLE;
      cnt_q     <= '0;
      hi_q      <= '0;
      lo_q      <= '0;
      done_q    <= 1'b0;
      mcand_q   <= '0;
      acc_q     <= '0;
      neg_res_q <= 1'b0;
      neg_rem_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      hi_q      <= hi_d;
      lo_q      <= lo_d;
      done_q    <= done_d;
      mcand_q   <= mcand_d;
      acc_q     <= acc_d;
      neg_res_q <= neg_res_d;
      neg_rem_q <= neg_rem_d;
    end
  end

  assign busy = (state_q != MDU_IDLE);
  assign done = done_q;
  assign hi   = hi_q;
  assign lo   = lo_q;

endmodule

`default_nettype wire

// File: tb/tb_hilo_mdu.sv
// ============================================================================
// Module   : tb_hilo_mdu
// Brief    : Self-checking bench for hilo_mdu: directed vectors, randomized
//            ops against an arithmetic reference model, MTHI/MTLO, busy
//            ignore, flush and mid-operation reset. Honours MDU_FAST_MUL_EN.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_hilo_mdu;

  localparam logic [5:0] F_MTHI  = 6'h11;
  localparam logic [5:0] F_MTLO  = 6'h13;
  localparam logic [5:0] F_MULT  = 6'h18;
  localparam logic [5:0] F_MULTU = 6'h19;
  localparam logic [5:0] F_DIV   = 6'h1A;
  localparam logic [5:0] F_DIVU  = 6'h1B;
  localparam int         N_ITERS = 32;

  logic        clk = 1'b0;
  logic        resetn = 1'b0;
  logic        start = 1'b0;
  logic        flush = 1'b0;
  logic [5:0]  func = 6'd0;
  logic [31:0] A = 32'd0;
  logic [31:0] B = 32'd0;
  logic        busy, done;
  logic [31:0] hi, lo;

  int n_chk  = 0;
  int n_fail = 0;

  hilo_mdu #(.ITERS(N_ITERS)) dut (
    .clk    (clk),
    .resetn (resetn),
    .start  (start),
    .func   (func),
    .A      (A),
    .B      (B),
    .flush  (flush),
    .busy   (busy),
    .done   (done),
    .hi     (hi),
    .lo     (lo)
  );

  always #5 clk = ~clk;

  // Reference: {hi,lo} from plain integer arithmetic.
  function automatic logic [63:0] model(input logic [5:0] f, input logic [31:0] a, input logic [31:0] b);
    longint sa, sb, q, r;
    logic [63:0] res;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    res = 64'd0;
    case (f)
      F_MULT:  res = 64'(sa * sb);
      F_MULTU: res = {32'd0, a} * {32'd0, b};
      F_DIVU:  res = (b == 32'd0) ? {a, 32'hFFFFFFFF} : {a % b, a / b};
      F_DIV: begin
        if (b == 32'd0) res = {a, (a[31] ? 32'h00000001 : 32'hFFFFFFFF)};
        else begin
          q = sa / sb;
          r = sa % sb;
          res = {r[31:0], q[31:0]};
        end
      end
      default: res = 64'd0;
    endcase
    return res;
  endfunction

  function automatic int exp_lat(input logic [5:0] f);
`ifdef MDU_FAST_MUL_EN
    if (f == F_MULT || f == F_MULTU) return 1;
`endif
    return (f == F_MULT || f == F_MULTU || f == F_DIV || f == F_DIVU) ? N_ITERS + 1 : 1;
  endfunction

  // Drive one op from a negedge; return at the negedge where done is seen.
  task automatic issue(input logic [5:0] f, input logic [31:0] a, input logic [31:0] b,
                       output int lat, output int bcnt, output logic [31:0] rhi, output logic [31:0] rlo);
    start = 1'b1; func = f; A = a; B = b;
    @(negedge clk);
    start = 1'b0; func = 6'd0; A = $urandom; B = $urandom;
    lat = 1; bcnt = 0;
    while (done !== 1'b1 && lat < 100) begin
      if (busy === 1'b1) bcnt++;
      @(negedge clk);
      lat++;
    end
    rhi = hi; rlo = lo;
  endtask

  task automatic test_reset();
    resetn = 1'b0;
    repeat (3) @(negedge clk);
    n_chk++; if (hi !== 32'd0)   begin n_fail++; $display("FAIL reset_hi got %h want 0", hi); end
    n_chk++; if (lo !== 32'd0)   begin n_fail++; $display("FAIL reset_lo got %h want 0", lo); end
    n_chk++; if (busy !== 1'b0)  begin n_fail++; $display("FAIL reset_busy got %b want 0", busy); end
    n_chk++; if (done !== 1'b0)  begin n_fail++; $display("FAIL reset_done got %b want 0", done); end
    resetn = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_directed();
    logic [5:0]  fv [5] = '{F_MULT, F_MULTU, F_DIV, F_DIVU, F_DIV};
    logic [31:0] av [5] = '{32'hFFFFFFFE, 32'hFFFFFFFF, 32'hFFFFFFF9, 32'd7, 32'h80000000};
    logic [31:0] bv [5] = '{32'd3, 32'hFFFFFFFF, 32'd2, 32'd0, 32'hFFFFFFFF};
    logic [63:0] ev [5] = '{64'hFFFFFFFF_FFFFFFFA, 64'hFFFFFFFE_00000001, 64'hFFFFFFFF_FFFFFFFD,
                            64'h00000007_FFFFFFFF, 64'h00000000_80000000};
    int lat, bcnt;
    logic [31:0] rhi, rlo;
    for (int i = 0; i < 5; i++) begin
      issue(fv[i], av[i], bv[i], lat, bcnt, rhi, rlo);
      n_chk++; if (lat !== exp_lat(fv[i])) begin n_fail++; $display("FAIL dir%0d_latency got %0d want %0d", i, lat, exp_lat(fv[i])); end
      n_chk++; if (bcnt !== exp_lat(fv[i]) - 1) begin n_fail++; $display("FAIL dir%0d_busy_cycles got %0d want %0d", i, bcnt, exp_lat(fv[i]) - 1); end
      n_chk++; if ({rhi, rlo} !== ev[i]) begin n_fail++; $display("FAIL dir%0d_result got %h_%h want %h", i, rhi, rlo, ev[i]); end
      @(negedge clk);
      n_chk++; if (done !== 1'b0) begin n_fail++; $display("FAIL dir%0d_done_pulse got %b want 0", i, done); end
    end
  endtask

  // Back-to-back random ops: each is issued in the done cycle of the last.
  task automatic test_random();
    logic [5:0]  fsel [4] = '{F_MULT, F_MULTU, F_DIV, F_DIVU};
    logic [5:0]  f;
    logic [31:0] a, b, rhi, rlo;
    logic [63:0] exp;
    int lat, bcnt;
    for (int i = 0; i < 24; i++) begin
      f = fsel[$urandom_range(0, 3)];
      a = $urandom;
      case ($urandom_range(0, 5))
        0: b = 32'd0;
        1: b = 32'hFFFFFFFF;
        2: b = $urandom_range(1, 9);
        default: b = $urandom;
      endcase
      exp = model(f, a, b);
      issue(f, a, b, lat, bcnt, rhi, rlo);
      n_chk++; if (lat !== exp_lat(f)) begin n_fail++; $display("FAIL rand%0d_latency f=%h got %0d want %0d", i, f, lat, exp_lat(f)); end
      n_chk++; if ({rhi, rlo} !== exp) begin n_fail++; $display("FAIL rand%0d_result f=%h a=%h b=%h got %h_%h want %h", i, f, a, b, rhi, rlo, exp); end
    end
    @(negedge clk);
  endtask

  task automatic test_mthi_mtlo();
    start = 1'b1; func = F_MTHI; A = 32'h1234;
    @(negedge clk);
    start = 1'b0;
    n_chk++; if (hi !== 32'h1234) begin n_fail++; $display("FAIL mthi_value got %h want 00001234", hi); end
    n_chk++; if (busy !== 1'b0)   begin n_fail++; $display("FAIL mthi_busy got %b want 0", busy); end
    n_chk++; if (done !== 1'b0)   begin n_fail++; $display("FAIL mthi_done got %b want 0", done); end
    start = 1'b1; func = F_MTLO; A = 32'hCAFE0001;
    @(negedge clk);
    start = 1'b0;
    n_chk++; if (lo !== 32'hCAFE0001) begin n_fail++; $display("FAIL mtlo_value got %h want cafe0001", lo); end
    n_chk++; if (hi !== 32'h1234)     begin n_fail++; $display("FAIL mtlo_hi_kept got %h want 00001234", hi); end
  endtask

  task automatic test_busy_ignore();
    int lat;
    logic [63:0] exp;
    exp = model(F_DIVU, 32'd1000, 32'd7);
    start = 1'b1; func = F_DIVU; A = 32'd1000; B = 32'd7;
    @(negedge clk);
    start = 1'b0;
    repeat (2) @(negedge clk);
    start = 1'b1; func = F_MTHI; A = 32'h5A5A5A5A; B = 32'd0;
    @(negedge clk);
    start = 1'b0;
    n_chk++; if (hi !== 32'h1234) begin n_fail++; $display("FAIL ignore_hi got %h want 00001234", hi); end
    n_chk++; if (busy !== 1'b1)   begin n_fail++; $display("FAIL ignore_busy got %b want 1", busy); end
    lat = 4;
    while (done !== 1'b1 && lat < 100) begin @(negedge clk); lat++; end
    n_chk++; if (lat !== N_ITERS + 1) begin n_fail++; $display("FAIL ignore_latency got %0d want %0d", lat, N_ITERS + 1); end
    n_chk++; if ({hi, lo} !== exp) begin n_fail++; $display("FAIL ignore_result got %h_%h want %h", hi, lo, exp); end
    @(negedge clk);
  endtask

  task automatic test_flush();
    logic [31:0] ohi, olo;
    int dseen;
    ohi = hi; olo = lo;
    start = 1'b1; func = F_DIV; A = 32'hFFFFFFF9; B = 32'd2;
    @(negedge clk);
    start = 1'b0;
    repeat (9) @(negedge clk);
    flush = 1'b1;
    @(negedge clk);
    flush = 1'b0;
    n_chk++; if (busy !== 1'b0) begin n_fail++; $display("FAIL flush_busy got %b want 0", busy); end
    n_chk++; if (hi !== ohi)    begin n_fail++; $display("FAIL flush_hi got %h want %h", hi, ohi); end
    n_chk++; if (lo !== olo)    begin n_fail++; $display("FAIL flush_lo got %h want %h", lo, olo); end
    dseen = 0;
    for (int i = 0; i < 40; i++) begin
      if (done === 1'b1) dseen++;
      @(negedge clk);
    end
    n_chk++; if (dseen !== 0) begin n_fail++; $display("FAIL flush_no_done got %0d pulses want 0", dseen); end
    flush = 1'b1; start = 1'b1; func = F_MTHI; A = 32'hBEEF;
    @(negedge clk);
    flush = 1'b0; start = 1'b0;
    n_chk++; if (hi !== ohi) begin n_fail++; $display("FAIL flush_mthi_hi got %h want %h", hi, ohi); end
    flush = 1'b1; start = 1'b1; func = F_MULT; A = 32'd5; B = 32'd6;
    @(negedge clk);
    flush = 1'b0; start = 1'b0;
    n_chk++; if (busy !== 1'b0) begin n_fail++; $display("FAIL flush_mult_busy got %b want 0", busy); end
    @(negedge clk);
    n_chk++; if (done !== 1'b0) begin n_fail++; $display("FAIL flush_mult_done got %b want 0", done); end
    n_chk++; if ({hi, lo} !== {ohi, olo}) begin n_fail++; $display("FAIL flush_mult_hilo got %h_%h want %h_%h", hi, lo, ohi, olo); end
  endtask

  task automatic test_reset_mid();
    start = 1'b1; func = F_MTHI; A = 32'h77;
    @(negedge clk);
    start = 1'b1; func = F_DIVU; A = 32'd99; B = 32'd4;
    @(negedge clk);
    start = 1'b0;
    repeat (4) @(negedge clk);
    resetn = 1'b0;
    @(negedge clk);
    n_chk++; if (hi !== 32'd0)  begin n_fail++; $display("FAIL midreset_hi got %h want 0", hi); end
    n_chk++; if (lo !== 32'd0)  begin n_fail++; $display("FAIL midreset_lo got %h want 0", lo); end
    n_chk++; if (busy !== 1'b0) begin n_fail++; $display("FAIL midreset_busy got %b want 0", busy); end
    resetn = 1'b1;
    repeat (40) @(negedge clk);
    n_chk++; if ({hi, lo} !== 64'd0) begin n_fail++; $display("FAIL midreset_after got %h_%h want 0", hi, lo); end
  endtask

  initial begin
    @(negedge clk);
    test_reset();
    test_directed();
    test_mthi_mtlo();
    test_busy_ignore();
    test_flush();
    test_random();
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
